// File: rtl/l2req_core_arbiter_pkg.sv
// Shared types and sizing for the L2 request arbiter.
// Cores hand packets of this shape to the L2 pipeline.
package l2req_core_arbiter_pkg;

   localparam int NUM_CORES        = 4;
   localparam int CORE_INDEX_WIDTH = 2;

   typedef struct packed {
      logic        valid;
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
   } l2req_packet_t;

endpackage

// File: rtl/l2req_core_arbiter_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr,
// wrapping past the top index back to zero.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] idx,
   output logic         any
);

   // scan N slots starting at ptr; first hit wins
   always_comb begin
      int j;
      j     = 0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = W'(j);
         end
      end
   end

endmodule

// File: rtl/l2req_core_arbiter.sv
// Arbitrates per-core L2 requests into one registered
// request slot feeding the L2 pipeline.
module l2req_core_arbiter
   import l2req_core_arbiter_pkg::l2req_packet_t;
#(
   parameter int NUM_CORES        = l2req_core_arbiter_pkg::NUM_CORES,
   parameter int CORE_INDEX_WIDTH = l2req_core_arbiter_pkg::CORE_INDEX_WIDTH
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  l2req_packet_t               core_l2req_packet [NUM_CORES],
   output logic [NUM_CORES-1:0]        core_l2req_ready,
   output l2req_packet_t               l2req_packet,
   input  logic                        l2req_ready,
   output logic [CORE_INDEX_WIDTH-1:0] grant_core,
   output logic                        pc_event_l2req_conflict,
   output logic                        pc_event_l2req_stall
);

   logic [NUM_CORES-1:0]        req;
   logic [NUM_CORES-1:0]        grant;
   logic [CORE_INDEX_WIDTH-1:0] idx;
   logic [CORE_INDEX_WIDTH-1:0] rr_ptr;
   logic                        any;
   logic                        free;
   logic                        take;

   // arbitration looks at .valid only
   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_CORES; i++)
         req[i] = core_l2req_packet[i].valid;
   end

   rr_arbiter #(
      .N (NUM_CORES),
      .W (CORE_INDEX_WIDTH)
   ) u_rr (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (idx),
      .any   (any)
   );

   // slot is free when empty or draining this cycle
   assign free = !l2req_packet.valid || l2req_ready;
   // reset_n gates ready so nothing is accepted in reset
   assign take = reset_n && free && any;

   assign core_l2req_ready        = take ? grant : '0;
   assign pc_event_l2req_conflict = take && ($countones(req) > 1);
   assign pc_event_l2req_stall    = l2req_packet.valid && !l2req_ready;

   // output slot, grant index and round-robin pointer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         l2req_packet <= '0;
         grant_core   <= '0;
         rr_ptr       <= '0;
      end else if (take) begin
         l2req_packet <= core_l2req_packet[idx];
         grant_core   <= idx;
         rr_ptr       <= (idx == CORE_INDEX_WIDTH'(NUM_CORES - 1))
                         ? '0 : idx + 1'b1;
      end else if (l2req_ready) begin
         l2req_packet.valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_l2req_core_arbiter.sv
// Scoreboard bench for the L2 request arbiter.
// Grants predicted at negedge are queued and popped on drain.
module tb_l2req_core_arbiter;
   import l2req_core_arbiter_pkg::l2req_packet_t;

   localparam int N = 4;
   localparam int W = 2;

   typedef struct {
      l2req_packet_t p;
      int            idx;
   } exp_t;

   logic          clk;
   logic          rst_n;
   l2req_packet_t pkt_in [N];
   logic [N-1:0]  rdy;
   l2req_packet_t out;
   logic          l2rdy;
   logic [W-1:0]  gcore;
   logic          conf;
   logic          stall;

   int   checks;
   int   errors;
   exp_t q[$];
   bit   m_valid;
   int   m_ptr;
   int   pend [N];

   l2req_core_arbiter #(
      .NUM_CORES        (N),
      .CORE_INDEX_WIDTH (W)
   ) u_dut (
      .clk                     (clk),
      .reset_n                 (rst_n),
      .core_l2req_packet       (pkt_in),
      .core_l2req_ready        (rdy),
      .l2req_packet            (out),
      .l2req_ready             (l2rdy),
      .grant_core              (gcore),
      .pc_event_l2req_conflict (conf),
      .pc_event_l2req_stall    (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic refresh(input int c);
      l2req_packet_t p;
      p.valid = 1'b1;
      p.op    = 2'($urandom);
      p.addr  = $urandom;
      p.data  = $urandom;
      if (pend[c] <= 0) p.valid = 1'b0;
      pkt_in[c] = p;
   endtask

   task automatic refresh_all();
      for (int c = 0; c < N; c++) refresh(c);
   endtask

   task automatic cyc();
      int            g;
      int            j;
      int            nreq;
      bit            free;
      logic [N-1:0]  erdy;
      exp_t          e;
      @(negedge clk);
      g    = -1;
      nreq = 0;
      free = !m_valid || l2rdy;
      for (int k = 0; k < N; k++) begin
         if (pkt_in[k].valid) nreq++;
         j = (m_ptr + k) % N;
         if (free && g < 0 && pkt_in[j].valid) g = j;
      end
      erdy = '0;
      if (g >= 0) erdy[g] = 1'b1;
      chk("ready", 128'(rdy), 128'(erdy));
      chk("conflict", 128'(conf), 128'(g >= 0 && nreq > 1));
      chk("stall", 128'(stall), 128'(m_valid && !l2rdy));
      chk("valid", 128'(out.valid), 128'(m_valid));
      chk("rr_ptr", 128'(u_dut.rr_ptr), 128'(m_ptr));
      if (m_valid) begin
         if (q.size() == 0) begin
            chk("sb_empty", 128'(1), 128'(0));
         end else begin
            e = q[0];
            chk("pkt", 128'(out), 128'(e.p));
            chk("grant_core", 128'(gcore), 128'(e.idx));
            if (l2rdy) void'(q.pop_front());
         end
      end
      if (g >= 0) begin
         e.p   = pkt_in[g];
         e.idx = g;
         q.push_back(e);
         m_valid = 1'b1;
         m_ptr   = (g + 1) % N;
         pend[g]--;
      end else if (l2rdy) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (g >= 0) refresh(g);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 100; k++) begin
         done = !m_valid && q.size() == 0;
         for (int c = 0; c < N; c++)
            if (pend[c] > 0) done = 1'b0;
         if (done) break;
         cyc();
      end
      if (!done) chk("drain_timeout", 128'(0), 128'(1));
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_valid"}, 128'(out.valid), 128'(0));
      chk({tag, "_pkt"}, 128'(out), 128'(0));
      chk({tag, "_gcore"}, 128'(gcore), 128'(0));
      chk({tag, "_ptr"}, 128'(u_dut.rr_ptr), 128'(0));
      chk({tag, "_ready"}, 128'(rdy), 128'(0));
      chk({tag, "_conf"}, 128'(conf), 128'(0));
      chk({tag, "_stall"}, 128'(stall), 128'(0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      reset_checks("rst");
      m_valid = 1'b0;
      m_ptr   = 0;
      q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_valid = 1'b0;
      m_ptr = 0;
      rst_n = 1'b0;
      l2rdy = 1'b0;
      for (int c = 0; c < N; c++) pend[c] = 1;
      refresh_all();
      repeat (2) @(posedge clk);
      #1;
      reset_checks("por");
      for (int c = 0; c < N; c++) pend[c] = 0;
      refresh_all();
      rst_n = 1'b1;

      // single request from core 2
      l2rdy = 1'b1;
      pend[2] = 1;
      refresh(2);
      drain();
      chk("single_ptr", 128'(m_ptr), 128'(3));

      // wrap: pointer at 3 with cores 0 and 3
      pend[0] = 1;
      pend[3] = 1;
      refresh(0);
      refresh(3);
      drain();

      // all four continuous from pointer 0
      do_reset();
      for (int c = 0; c < N; c++) pend[c] = 3;
      refresh_all();
      drain();

      // stall with register full, cores 1 and 3 waiting
      l2rdy = 1'b0;
      pend[0] = 1;
      refresh(0);
      cyc();
      pend[1] = 1;
      pend[3] = 1;
      refresh(1);
      refresh(3);
      repeat (3) cyc();
      l2rdy = 1'b1;
      drain();

      // drain and refill back to back
      pend[0] = 3;
      refresh(0);
      drain();

      // reset while stalled
      l2rdy = 1'b0;
      pend[1] = 2;
      refresh(1);
      cyc();
      cyc();
      rst_n = 1'b0;
      #1;
      reset_checks("mid");
      m_valid = 1'b0;
      m_ptr = 0;
      q.delete();
      for (int c = 0; c < N; c++) pend[c] = 0;
      pend[3] = 1;
      refresh_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      l2rdy = 1'b1;
      drain();

      // random traffic and backpressure
      for (int k = 0; k < 300; k++) begin
         l2rdy = ($urandom % 4) != 0;
         for (int c = 0; c < N; c++) begin
            if (pend[c] == 0 && ($urandom % 3) == 0) begin
               pend[c] = 1 + int'($urandom % 3);
               refresh(c);
            end
         end
         cyc();
      end
      l2rdy = 1'b1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
